if_fetch_unit: RTL

Fetch-side producer for the decode-stage PC/instruction pipeline register. It owns the architectural fetch PC and issues one-outstanding word requests to instruction memory. It delivers {pc, pc+4, instr, valid} to the decode stage, honouring stall from the hazard unit and redirect (branch/jump/flush) from execute.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fetch_unit_if.sv | 35 +++
 rtl/if_fetch_unit_hold_buffer.sv | 30 +++
 rtl/if_fetch_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package if_fetch_unit_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_INC       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch unit bus: hazard/redirect controls, imem request/response, decode-stage entry.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            fd_valid;
  logic [XLEN-1:0] fd_pc;
  logic [XLEN-1:0] fd_pc_plus4;
  logic [XLEN-1:0] fd_instr;

  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr,
    output fd_valid, fd_pc, fd_pc_plus4, fd_instr
  );

  modport slave (
    output stall, redirect_valid, redirect_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr,
    input  fd_valid, fd_pc, fd_pc_plus4, fd_instr
  );

endinterface

// File: rtl/if_fetch_unit_hold_buffer.sv
// One-entry instr/pc buffer that parks a response while decode is stalled.
module if_fetch_unit_hold_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clr,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= '0;
      pc    <= '0;
    end else if (clr) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= instr_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch PC owner: single-outstanding imem requests feeding the decode-stage register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_unit_if.master       bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            deliver, from_hold, hold_load, hold_clr;
  logic [XLEN-1:0] hold_instr, hold_pc;
  logic [XLEN-1:0] redirect_tgt, pc_inc, deliver_pc, deliver_instr;
  logic            fd_valid_q;
  logic [XLEN-1:0] fd_pc_q, fd_pc_plus4_q, fd_instr_q;

  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);
  assign pc_inc       = pc_q + XLEN'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    deliver   = 1'b0;
    from_hold = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;
    if (bus.redirect_valid) begin
      // Redirect wins; a request already accepted must have its response discarded.
      pc_d = redirect_tgt;
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (bus.imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end
        S_HOLD: begin
          hold_clr = 1'b1;
          state_d  = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (bus.imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (!bus.stall) begin
              deliver = 1'b1;
              pc_d    = pc_inc;
              state_d = S_REQ;
            end else begin
              hold_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!bus.stall) begin
            deliver   = 1'b1;
            from_hold = 1'b1;
            pc_d      = pc_inc;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  if_fetch_unit_hold_buffer #(.XLEN(XLEN)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (hold_load),
    .clr     (hold_clr),
    .instr_d (bus.imem_rsp_data),
    .pc_d    (pc_q),
    .instr   (hold_instr),
    .pc      (hold_pc)
  );

  assign deliver_pc    = from_hold ? hold_pc    : pc_q;
  assign deliver_instr = from_hold ? hold_instr : bus.imem_rsp_data;

  // Decode-stage register boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_valid_q    <= 1'b0;
      fd_pc_q       <= '0;
      fd_pc_plus4_q <= '0;
      fd_instr_q    <= '0;
    end else if (bus.redirect_valid) begin
      fd_valid_q <= 1'b0;
    end else if (deliver) begin
      fd_valid_q    <= 1'b1;
      fd_pc_q       <= deliver_pc;
      fd_pc_plus4_q <= deliver_pc + XLEN'(PC_INC);
      fd_instr_q    <= deliver_instr;
    end else if (!bus.stall) begin
      fd_valid_q <= 1'b0;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.fd_valid       = fd_valid_q;
  assign bus.fd_pc          = fd_pc_q;
  assign bus.fd_pc_plus4    = fd_pc_plus4_q;
  assign bus.fd_instr       = fd_instr_q;

endmodule
